sseg_ascii_scan: RTL and testbench

- Downstream display stage for the board demos: takes a 4-character ASCII word from the demo top's mode/case logic (e.g. "nand", "bus1") and drives the Basys3 4-digit 7-segment display.
- Time-multiplexes the digits, decodes ASCII to segment patterns, and inserts inter-digit blanking to suppress ghosting.
- Snapshots the word once per frame so a word change never shows a torn mix of old and new characters.

---
 rtl/sseg_ascii_scan.sv | 126 ++++++++++++
 tb/tb_sseg_ascii_scan.sv | 128 ++++++++++++
 2 files changed

// File: rtl/sseg_ascii_scan.sv
// Four-digit multiplexed 7-segment driver for a 4-character ASCII word.
// The word is snapshotted once per frame so the digits never show a mix of two words.
module sseg_ascii_scan #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned BLANK    = 1000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] WORD,
  input  logic [3:0]  DOTS,
  output logic [6:0]  SEG,
  output logic [3:0]  AN,
  output logic        DP,
  output logic        FRAME
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK);

  localparam logic [6:0] SEG_OFF     = 7'b1111111;
  localparam logic [6:0] SEG_ILLEGAL = 7'b0110110;

  // Active-low segment pattern, bit order g..a.
  function automatic logic [6:0] font(input logic [7:0] ch);
    logic [7:0] c;
    logic [6:0] s;
    c = ch;
    if (c >= 8'h41 && c <= 8'h5A) c = c | 8'h20;
    unique case (c)
      "0":     s = 7'b1000000;
      "1":     s = 7'b1111001;
      "2":     s = 7'b0100100;
      "3":     s = 7'b0110000;
      "4":     s = 7'b0011001;
      "5":     s = 7'b0010010;
      "6":     s = 7'b0000010;
      "7":     s = 7'b1111000;
      "8":     s = 7'b0000000;
      "9":     s = 7'b0010000;
      "a":     s = 7'b0100000;
      "b":     s = 7'b0000011;
      "c":     s = 7'b0100111;
      "d":     s = 7'b0100001;
      "e":     s = 7'b0000110;
      "f":     s = 7'b0001110;
      "g":     s = 7'b1000010;
      "h":     s = 7'b0001011;
      "i":     s = 7'b1111011;
      "j":     s = 7'b1100001;
      "l":     s = 7'b1000111;
      "n":     s = 7'b0101011;
      "o":     s = 7'b0100011;
      "p":     s = 7'b0001100;
      "q":     s = 7'b0011000;
      "r":     s = 7'b0101111;
      "s":     s = 7'b0010010;
      "t":     s = 7'b0000111;
      "u":     s = 7'b1100011;
      "y":     s = 7'b0010001;
      "z":     s = 7'b0100100;
      " ":     s = SEG_OFF;
      "-":     s = 7'b0111111;
      "_":     s = 7'b1110111;
      default: s = SEG_ILLEGAL;
    endcase
    return s;
  endfunction

  logic [CW-1:0] cnt_q;
  logic [1:0]    idx_q;
  logic [31:0]   wsnap_q;
  logic [3:0]    dsnap_q;
  logic [6:0]    seg_q;
  logic [3:0]    an_q;
  logic          dp_q;
  logic          frame_q;

  logic [7:0]    cur_char;
  logic [6:0]    cur_seg;
  logic [3:0]    cur_an;
  logic          slot_end;

  always_comb begin
    cur_char = wsnap_q[{idx_q, 3'b000} +: 8];
    cur_seg  = font(cur_char);
    cur_an   = (cnt_q < BLANK_C) ? 4'b1111 : ~(4'b0001 << idx_q);
    slot_end = (cnt_q == CNT_MAX);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      wsnap_q <= 32'h2020_2020;
      dsnap_q <= 4'b0000;
      seg_q   <= SEG_OFF;
      an_q    <= 4'b1111;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      frame_q <= 1'b0;
      if (slot_end) begin
        cnt_q <= '0;
        idx_q <= idx_q + 2'd1;
        // End of the AN3 slot closes the frame: latch the next word here.
        if (idx_q == 2'd3) begin
          wsnap_q <= WORD;
          dsnap_q <= DOTS;
          frame_q <= 1'b1;
        end
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
      an_q  <= cur_an;
      seg_q <= cur_seg;
      dp_q  <= ~dsnap_q[idx_q];
    end
  end

  assign SEG   = seg_q;
  assign AN    = an_q;
  assign DP    = dp_q;
  assign FRAME = frame_q;

endmodule

// File: tb/tb_sseg_ascii_scan.sv
// Directed bench for sseg_ascii_scan with SCAN_DIV=8, BLANK=2 (32-cycle frames).
module tb_sseg_ascii_scan;

  logic        CLK;
  logic        RST;
  logic [31:0] WORD;
  logic [3:0]  DOTS;
  logic [6:0]  SEG;
  logic [3:0]  AN;
  logic        DP;
  logic        FRAME;

  int n_chk = 0;
  int n_bad = 0;

  localparam logic [6:0] G_SP  = 7'b1111111;
  localparam logic [6:0] G_N   = 7'b0101011;
  localparam logic [6:0] G_A   = 7'b0100000;
  localparam logic [6:0] G_D   = 7'b0100001;
  localparam logic [6:0] G_ILL = 7'b0110110;
  localparam logic [6:0] G_O   = 7'b0100011;
  localparam logic [6:0] G_R   = 7'b0101111;
  localparam logic [6:0] G_0   = 7'b1000000;
  localparam logic [6:0] G_1   = 7'b1111001;
  localparam logic [6:0] G_DSH = 7'b0111111;

  sseg_ascii_scan #(
    .SCAN_DIV(8),
    .BLANK   (2)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .WORD (WORD),
    .DOTS (DOTS),
    .SEG  (SEG),
    .AN   (AN),
    .DP   (DP),
    .FRAME(FRAME)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " an"}, {28'd0, AN}, 32'hF);
    check({tag, " seg"}, {25'd0, SEG}, {25'd0, G_SP});
    check({tag, " dp"}, {31'd0, DP}, 32'd1);
    check({tag, " frame"}, {31'd0, FRAME}, 32'd0);
  endtask

  // Checks the 32 cycles after a FRAME pulse (or after reset release).
  // segs packs expected glyphs {AN3,AN2,AN1,AN0}; seg_en masks digits with unchecked glyphs.
  // At cycle chg_j the inputs are switched to nw/nd.
  task automatic check_frame(input string name, input logic [27:0] segs,
                             input logic [3:0] seg_en, input logic [3:0] dots,
                             input int chg_j, input logic [31:0] nw, input logic [3:0] nd);
    int p, ix, c;
    logic [3:0] ean;
    logic [6:0] eseg;
    for (int j = 1; j <= 32; j++) begin
      @(posedge CLK);
      @(negedge CLK);
      p    = j - 1;
      ix   = p / 8;
      c    = p % 8;
      ean  = (c < 2) ? 4'b1111 : ~(4'b0001 << ix);
      eseg = segs[7*ix +: 7];
      check($sformatf("%s an j%0d", name, j), {28'd0, AN}, {28'd0, ean});
      if (seg_en[ix])
        check($sformatf("%s seg j%0d", name, j), {25'd0, SEG}, {25'd0, eseg});
      check($sformatf("%s dp j%0d", name, j), {31'd0, DP}, {31'd0, ~dots[ix]});
      check($sformatf("%s frame j%0d", name, j), {31'd0, FRAME}, {31'd0, j == 32});
      if (j == chg_j) begin
        WORD = nw;
        DOTS = nd;
      end
    end
  endtask

  initial begin
    RST  = 1'b1;
    WORD = "nand";
    DOTS = 4'b0000;

    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      check_reset_outputs($sformatf("rst%0d", i));
    end
    RST = 1'b0;

    // First frame shows the blank reset snapshot; "nand" is latched at its end.
    check_frame("blank", {G_SP, G_SP, G_SP, G_SP}, 4'hF, 4'h0, 0, 32'd0, 4'h0);
    // Word changes mid-frame (AN1 active at j=12) must not tear the frame.
    check_frame("nand", {G_N, G_A, G_N, G_D}, 4'hF, 4'h0, 12, " xor", 4'h0);
    check_frame("xor", {G_SP, G_ILL, G_O, G_R}, 4'hF, 4'h0, 5, "01- ", 4'h0);
    check_frame("01-", {G_0, G_1, G_DSH, G_SP}, 4'hF, 4'h0, 20, "#$Aa", 4'h0);
    check_frame("sym", {G_ILL, G_ILL, G_A, G_A}, 4'hF, 4'h0, 30, "bus1", 4'b0101);
    check_frame("bus1", {G_SP, G_SP, G_SP, G_1}, 4'b0001, 4'b0101, 0, 32'd0, 4'h0);

    // Reset for one cycle while AN2 is lit.
    repeat (20) begin
      @(posedge CLK);
      @(negedge CLK);
    end
    check("pre-rst an2", {28'd0, AN}, 32'hB);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs("midrst");
    RST = 1'b0;

    check_frame("reblank", {G_SP, G_SP, G_SP, G_SP}, 4'hF, 4'h0, 0, 32'd0, 4'h0);
    check_frame("rebus1", {G_SP, G_SP, G_SP, G_1}, 4'b0001, 4'b0101, 0, 32'd0, 4'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
